// File: rtl/pwm_gen.sv
// PWM generator paced by a synchronised, edge-detected divided clock; duty changes land on period boundaries.
// Define PWM_CENTER_ALIGN_EN for up/down (centre-aligned) counting; otherwise an edge-aligned sawtooth is built.
module pwm_gen #(
    parameter int PERIOD      = 256,
    parameter int SYNC_STAGES = 2,
    localparam int DW         = $clog2(PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_clk,
    input  logic          enable,
    input  logic [DW-1:0] duty_in,
    input  logic          duty_load,
    output logic          pwm_out,
    output logic          period_start,
    output logic          duty_busy
);

    localparam logic [DW-1:0] LAST     = DW'(PERIOD - 1);
    localparam logic [DW-1:0] PERIOD_W = DW'(PERIOD);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out_d_q;
    logic                   tick;

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_act_q, duty_act_d;
    logic [DW-1:0] duty_pend_q, duty_pend_d;
    logic          busy_q, busy_d;
    logic          pwm_q, pwm_d;
    logic          period_start_q, period_start_d;
    logic [DW-1:0] duty_clamp;
    logic          wrap;

`ifdef PWM_CENTER_ALIGN_EN
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
    dir_t dir_q, dir_d;
`endif

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            assign sync_d[gi] = div_clk;
        end else begin : g_rest
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    assign tick       = sync_q[SYNC_STAGES-1] & ~sync_out_d_q;
    assign duty_clamp = (duty_in > PERIOD_W) ? PERIOD_W : duty_in;

    always_comb begin
        cnt_d          = cnt_q;
        duty_act_d     = duty_act_q;
        duty_pend_d    = duty_pend_q;
        busy_d         = busy_q;
        period_start_d = 1'b0;
        wrap           = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d          = dir_q;
`endif
        if (!enable) begin
            cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_d = DIR_UP;
`endif
            if (busy_q) begin
                duty_act_d = duty_pend_q;
                busy_d     = 1'b0;
            end
            if (duty_load) begin
                duty_pend_d = duty_clamp;
                busy_d      = 1'b1;
            end
        end else begin
            if (tick) begin
`ifdef PWM_CENTER_ALIGN_EN
                if (dir_q == DIR_UP) begin
                    if (cnt_q == LAST) begin
                        cnt_d = LAST - DW'(1);
                        dir_d = DIR_DOWN;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
                // Reaching the bottom ends a period, including the PERIOD=2 top-to-bottom case.
                if (cnt_d == '0) begin
                    dir_d = DIR_UP;
                    wrap  = 1'b1;
                end
`else
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
`endif
            end
            if (wrap) begin
                period_start_d = 1'b1;
                if (duty_load) begin
                    duty_act_d  = duty_clamp;
                    duty_pend_d = duty_clamp;
                    busy_d      = 1'b0;
                end else if (busy_q) begin
                    duty_act_d = duty_pend_q;
                    busy_d     = 1'b0;
                end
            end else if (duty_load) begin
                duty_pend_d = duty_clamp;
                busy_d      = 1'b1;
            end
        end
        pwm_d = enable & (cnt_d < duty_act_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '0;
            sync_out_d_q   <= 1'b0;
            cnt_q          <= '0;
            duty_act_q     <= '0;
            duty_pend_q    <= '0;
            busy_q         <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q          <= DIR_UP;
`endif
        end else begin
            sync_q         <= sync_d;
            sync_out_d_q   <= sync_q[SYNC_STAGES-1];
            cnt_q          <= cnt_d;
            duty_act_q     <= duty_act_d;
            duty_pend_q    <= duty_pend_d;
            busy_q         <= busy_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_q          <= dir_d;
`endif
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign duty_busy    = busy_q;

endmodule
